// File: rtl/spike_pkg.sv
// Shared constants and slot-state type for the spike rate decoder.
package spike_pkg;

  localparam int unsigned OUT_W_DEF    = 8;
  localparam int unsigned WIN_LOG2_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Valid/ready output slot carrying the decoded rate.
interface spike_rate_decoder_if
  import spike_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEF
);

  logic [OUT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_ready;

  modport master (output rate, output rate_valid, input rate_ready);
  modport slave  (input rate, input rate_valid, output rate_ready);

endinterface

// File: rtl/spike_window_counter.sv
// Counts strobes and spikes over a 2^WIN_LOG2-strobe window; on the last
// strobe of a window emits a one-cycle close pulse with the saturated sample.
module spike_window_counter
  import spike_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  output logic             close,
  output logic [OUT_W-1:0] sample
);

  localparam logic [WIN_LOG2:0] SAT = (WIN_LOG2+1)'((1 << OUT_W) - 1);

  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   spk_cnt;
  logic [WIN_LOG2:0]   total;
  logic [WIN_LOG2:0]   shifted;

  assign close   = en & (&win_cnt);
  assign total   = spk_cnt + {{WIN_LOG2{1'b0}}, spike};
  assign shifted = total >> (WIN_LOG2 - OUT_W);
  assign sample  = (shifted > SAT) ? '1 : shifted[OUT_W-1:0];

  // Advance window position and spike tally on each strobe; clear tally at close.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_cnt <= '0;
      spk_cnt <= '0;
    end else if (en) begin
      win_cnt <= win_cnt + WIN_LOG2'(1);
      spk_cnt <= close ? '0 : total;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: windowed spike count presented on a valid/ready slot.
// Optional exponential smoothing of results when SPIKE_RATE_EMA_EN is defined.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int unsigned WIN_LOG2  = WIN_LOG2_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned EMA_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 spike,
  spike_rate_decoder_if.master out,
  output logic                 overrun
);

  if (WIN_LOG2 < OUT_W || EMA_SHIFT > OUT_W) begin : g_bad_cfg
    $error("spike_rate_decoder: need WIN_LOG2 >= OUT_W and EMA_SHIFT <= OUT_W");
  end

  slot_state_t      state, state_next;
  logic             close;
  logic             accept;
  logic [OUT_W-1:0] sample;
  logic [OUT_W-1:0] load_val;

  spike_window_counter #(
    .WIN_LOG2 (WIN_LOG2),
    .OUT_W    (OUT_W)
  ) u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .spike  (spike),
    .close  (close),
    .sample (sample)
  );

  assign accept         = (state == FULL) & out.rate_ready;
  assign out.rate_valid = (state == FULL);

`ifdef SPIKE_RATE_EMA_EN
  logic                primed;
  logic signed [OUT_W:0] diff;
  logic signed [OUT_W:0] step;
  logic signed [OUT_W:0] sum;

  // Move the held rate a 2^-EMA_SHIFT fraction toward the new sample.
  always_comb begin
    diff     = $signed({1'b0, sample}) - $signed({1'b0, out.rate});
    step     = diff >>> EMA_SHIFT;
    sum      = $signed({1'b0, out.rate}) + step;
    load_val = primed ? sum[OUT_W-1:0] : sample;
  end

  // First result after reset seeds the average directly.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      primed <= 1'b0;
    end else if (close) begin
      primed <= 1'b1;
    end
  end
`else
  assign load_val = sample;
`endif

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Slot next-state: fill on close, drain on accept unless refilled that cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (close) state_next = FULL;
      FULL:  if (accept && !close) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Load results into the slot; flag any result overwritten before acceptance.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out.rate <= '0;
      overrun  <= 1'b0;
    end else if (close) begin
      out.rate <= load_val;
      if (state == FULL && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder (WIN_LOG2=8, OUT_W=8, EMA_SHIFT=2).
module tb_spike_rate_decoder;

  localparam int WIN  = 256;
  localparam int SHFT = 2;

`ifdef SPIKE_RATE_EMA_EN
  localparam int S4_EXP = 80;
  localparam int S6_EXP = 207;
  localparam int E2_EXP = 32;
  localparam int E3_EXP = 56;
`else
  localparam int S4_EXP = 128;
  localparam int S6_EXP = 64;
  localparam int E2_EXP = 128;
  localparam int E3_EXP = 128;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic spike = 1'b0;
  logic ready = 1'b0;
  logic overrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spike_rate_decoder_if #(.OUT_W(8)) bus ();
  assign bus.rate_ready = ready;

  spike_rate_decoder #(
    .WIN_LOG2  (8),
    .OUT_W     (8),
    .EMA_SHIFT (SHFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .spike   (spike),
    .out     (bus),
    .overrun (overrun)
  );

  // Behavioural model: strobe/spike tallies and slot contents as integers.
  int m_strobes = 0;
  int m_spikes = 0;
  int m_rate = 0;
  int m_valid = 0;
  int m_ovr = 0;
  int m_primed = 0;
  bit m_live = 1'b0;

  always @(posedge clk) begin : model
    int acc, s, d, st;
    if (rst_n) begin
      m_strobes = 0; m_spikes = 0; m_rate = 0;
      m_valid = 0; m_ovr = 0; m_primed = 0; m_live = 1'b1;
    end else begin
      acc = (m_valid != 0 && ready) ? 1 : 0;
      if (en) begin
        m_spikes += int'(spike);
        m_strobes += 1;
      end
      if (en && m_strobes == WIN) begin
        s = (m_spikes > 255) ? 255 : m_spikes;
`ifdef SPIKE_RATE_EMA_EN
        if (m_primed != 0) begin
          d  = s - m_rate;
          st = (d >= 0) ? d / (1 << SHFT) : -((-d + (1 << SHFT) - 1) / (1 << SHFT));
          s  = (m_rate + st) & 255;
        end
`endif
        m_primed = 1;
        if (m_valid != 0 && acc == 0) m_ovr = 1;
        m_rate = s;
        m_valid = 1;
        m_strobes = 0;
        m_spikes = 0;
      end else if (acc != 0) begin
        m_valid = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("model_rate", 32'(bus.rate), 32'(m_rate));
      check("model_valid", 32'(bus.rate_valid), 32'(m_valid));
      check("model_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic cyc(input logic e, input logic s, input logic r);
    en = e; spike = s; ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst_n = 1'b0;
  endtask

  // n strobes starting at window index first; spike when index%period==period-1,
  // gap idle cycles before each strobe.
  task automatic win(input int first, input int n, input int period, input int gap, input logic r);
    for (int i = first; i < first + n; i++) begin
      repeat (gap) cyc(0, 0, r);
      cyc(1, (period > 0) && (i % period == period - 1), r);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    #1;
    do_reset();
    check("reset_rate", 32'(bus.rate), 0);
    check("reset_valid", 32'(bus.rate_valid), 0);
    check("reset_overrun", 32'(overrun), 0);

    // All-zero window.
    win(0, 255, 0, 0, 0);
    check("zero_not_yet", 32'(bus.rate_valid), 0);
    win(255, 1, 0, 0, 0);
    check("zero_valid", 32'(bus.rate_valid), 1);
    check("zero_rate", 32'(bus.rate), 0);
    cyc(0, 0, 1);
    check("zero_drained", 32'(bus.rate_valid), 0);

    // All-ones window saturates.
    do_reset();
    win(0, 256, 1, 0, 0);
    check("sat_rate", 32'(bus.rate), 255);
    check("sat_valid", 32'(bus.rate_valid), 1);

    // Every 4th strobe, then with en every 3rd cycle.
    do_reset();
    win(0, 256, 4, 0, 0);
    check("quarter_rate", 32'(bus.rate), 64);
    do_reset();
    win(0, 255, 4, 2, 0);
    check("slow_not_yet", 32'(bus.rate_valid), 0);
    win(255, 1, 4, 2, 0);
    check("slow_valid", 32'(bus.rate_valid), 1);
    check("slow_rate", 32'(bus.rate), 64);

    // Overwrite without accept.
    do_reset();
    win(0, 256, 4, 0, 0);
    check("ovr_first_rate", 32'(bus.rate), 64);
    check("ovr_first_flag", 32'(overrun), 0);
    win(0, 256, 2, 0, 0);
    check("ovr_second_rate", 32'(bus.rate), 32'(S4_EXP));
    check("ovr_second_flag", 32'(overrun), 1);
    cyc(0, 0, 1);
    check("ovr_drained", 32'(bus.rate_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_rate_hold", 32'(bus.rate), 32'(S4_EXP));

    // Reset mid-window, with en/ready also asserted during reset.
    win(0, 100, 1, 0, 0);
    rst_n = 1'b1;
    cyc(1, 1, 1);
    rst_n = 1'b0;
    check("midrst_rate", 32'(bus.rate), 0);
    check("midrst_valid", 32'(bus.rate_valid), 0);
    check("midrst_overrun", 32'(overrun), 0);
    win(0, 255, 1, 0, 0);
    check("midrst_not_yet", 32'(bus.rate_valid), 0);
    win(255, 1, 1, 0, 0);
    check("midrst_valid2", 32'(bus.rate_valid), 1);
    check("midrst_rate2", 32'(bus.rate), 255);

    // Close and accept in the same cycle.
    win(0, 255, 4, 0, 0);
    check("same_hold_rate", 32'(bus.rate), 255);
    win(255, 1, 4, 0, 1);
    check("same_rate", 32'(bus.rate), 32'(S6_EXP));
    check("same_valid", 32'(bus.rate_valid), 1);
    check("same_overrun", 32'(overrun), 0);

    // Windows of 0, 128, 128 spikes with the consumer always ready.
    do_reset();
    win(0, 256, 0, 0, 1);
    check("seq_rate1", 32'(bus.rate), 0);
    win(0, 256, 2, 0, 1);
    check("seq_rate2", 32'(bus.rate), 32'(E2_EXP));
    win(0, 256, 2, 0, 1);
    check("seq_rate3", 32'(bus.rate), 32'(E3_EXP));
    cyc(0, 0, 1);
    cyc(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder for spike trains produced by the `lif` neuron. It counts spikes over a fixed window of sample strobes and converts the count to an `OUT_W`-bit rate value, so a spike train can be turned back into a magnitude comparable to the `I` drive of `lif`. Each result is presented on a valid/ready output slot. It sits downstream of `lif`, sharing its clock and the same divided sample strobe.

## Interface
- `WIN_LOG2`, 8: window length is 2^WIN_LOG2 strobes; must be ≥ `OUT_W`.
- `OUT_W`, 8: rate output width.
- `EMA_SHIFT`, 2: smoothing shift; used only with `SPIKE_RATE_EMA_EN`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset (1 = reset). The name matches the `lif` reset port.
- `en`  in  1  sample strobe; one sample per cycle with `en`=1.
- `spike`  in  1  spike level, sampled only when `en`=1.
- `rate`  out  OUT_W  decoded rate.
- `rate_valid`  out  1  output slot holds an unconsumed result.
- `rate_ready`  in  1  consumer accepts `rate` when `rate_valid` && `rate_ready`.
- `overrun`  out  1  sticky; a result was overwritten before it was accepted.

## Operation
- `win_cnt` (WIN_LOG2 bits) increments on every `en`. It wraps from all-ones to 0.
- `spk_cnt` (WIN_LOG2+1 bits) adds `spike` on every `en`.
- Window close is an `en` cycle with `win_cnt` all-ones. On that cycle:
  - total = `spk_cnt` + `spike`, range 0..2^WIN_LOG2.
  - sample = total >> (WIN_LOG2-OUT_W), saturated to 2^OUT_W-1.
  - `spk_cnt` clears to 0, so the next window starts clean.
- The output slot is a two-state FSM:
  - EMPTY: `rate_valid`=0.
  - FULL: `rate_valid`=1.
- FSM transitions:
  - EMPTY, window close → load `rate`, go to FULL.
  - FULL, accept with no close → go to EMPTY; `rate` holds its value.
  - FULL, close and accept in the same cycle → load the new result, stay FULL, no overrun.
  - FULL, close without accept → overwrite `rate`, set `overrun`, stay FULL.
- `en`=0 freezes both counters. `rate_ready` is ignored in EMPTY.

## Timing
- Reset values: `rate`=0, `rate_valid`=0, `overrun`=0, FSM=EMPTY, both counters 0.
- Latency: `rate` and `rate_valid` update on the clock edge ending the closing `en` cycle. They are visible 1 cycle later.
- `rate_valid` never drops without an accept. `rate` is stable while `rate_valid`=1, except on an overwrite.
- Reset asserted mid-window discards the partial counts. After release, the first result needs a full 2^WIN_LOG2 strobes.
- Reset takes priority over `en` and `rate_ready` in the same cycle.
- `overrun` clears only on reset.

## Configuration
- Macro `SPIKE_RATE_EMA_EN`.
- When defined:
  - The loaded value is `rate` + ((sample - `rate`) >>> EMA_SHIFT).
  - Arithmetic is signed, OUT_W+1 bits, truncated back to OUT_W bits.
  - The first result after reset loads sample directly; an internal `primed` flag is cleared by reset.
- When undefined: the loaded value is sample, and `primed` and the smoothing logic are absent.

## Structure
- Shared package `spike_pkg`: default `OUT_W`/`WIN_LOG2` constants and the slot-state enum typedef (EMPTY, FULL).
- One sub-module, `spike_window_counter`:
  - Holds `win_cnt` and `spk_cnt`.
  - Emits a one-cycle `close` pulse and the saturated `sample`.
- The top holds the slot FSM, the EMA logic and `overrun`.

## Test plan
All scenarios use WIN_LOG2=8, OUT_W=8 and `en`=1 every cycle unless stated.
- Directed scenarios:
  - `spike`=0 for 256 strobes → `rate`=0, `rate_valid`=1 one cycle after strobe 256.
  - `spike`=1 for 256 strobes → total 256 saturates, `rate`=255.
  - `spike`=1 on every 4th strobe → `rate`=64. Repeat with `en` every 3rd cycle → same `rate`, and `rate_valid` rises 1 cycle after strobe 256.
  - `rate_ready`=0 across two windows (64 then 128 spikes) → `rate`=128, `overrun`=1. Then `rate_ready`=1 for one cycle → `rate_valid`=0, `overrun` stays 1.
  - Reset at strobe 100 of a window, then `spike`=1 constantly → all outputs 0. The next `rate_valid` arrives 256 strobes after release with `rate`=255.
  - With `SPIKE_RATE_EMA_EN` and EMA_SHIFT=2: windows of 0, 128, 128 spikes → `rate` 0, 32, 56.
- Also cover: window close and accept in the same cycle → new value, `rate_valid` stays 1, `overrun`=0.
